dds_wave_gen: RTL and testbench

- Numerically controlled oscillator: phase accumulator, phase offset, waveform shaper.
- Produces 16-bit offset-binary samples (0x8000 = zero) of the format the AM stage takes on its carrier and sig_mod inputs.
- Two instances sit directly upstream of the AM modulator: one for the carrier, one for the modulating tone.
- Sine uses a quarter-wave ROM; square, triangle and sawtooth are derived from phase.

---
 rtl/dds_wave_gen.sv | 126 ++++++++++++
 tb/tb_dds_wave_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// Numerically controlled oscillator: phase accumulator, phase offset and a
// four-waveform shaper (quarter-wave sine ROM, square, triangle, sawtooth).
module dds_wave_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned LUT_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_load,
  input  logic [15:0]        poff,
  input  logic [1:0]         wsel,
  input  logic               sync,
  output logic [15:0]        dout,
  output logic               dout_valid
);

  localparam int unsigned ROM_N   = 2 ** LUT_AW;
  localparam int unsigned PH_KEEP = (LUT_AW + 2 > 17) ? LUT_AW + 2 : 17;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_t;

  // Half-sample offset keeps the mirrored quadrants exactly symmetric.
  logic [14:0] rom [ROM_N];
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam real ANG = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(ROM_N);
    assign rom[k] = 15'($rtoi(32767.0 * $sin(ANG) + 0.5));
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_act;

  // Only the top phase bits are carried: the offset has no bits below them,
  // so no carry can enter this slice from the discarded low part.
  logic [PH_KEEP-1:0] ph_s1;
  wave_t              wsel_s1;
  logic               ce_s1;

  logic [LUT_AW-1:0]  addr_s2;
  logic               q1_s2;
  logic [16:0]        ph_s2;
  wave_t              wsel_s2;
  logic               ce_s2;

  logic [14:0]        rom_q;
  logic               q1_s3;
  logic [16:0]        ph_s3;
  wave_t              wsel_s3;
  logic               ce_s3;
  logic               ce_s4;

  logic [LUT_AW-1:0]  idx;
  logic [15:0]        tri_field;
  logic [15:0]        wave_next;

  assign idx       = ph_s1[PH_KEEP-3 -: LUT_AW];
  assign tri_field = ph_s3[15:0];

  always_comb begin
    wave_next = 16'h8000;
    case (wsel_s3)
      WAVE_SINE:   wave_next = q1_s3 ? 16'd32768 - {1'b0, rom_q} : 16'd32768 + {1'b0, rom_q};
      WAVE_SQUARE: wave_next = ph_s3[16] ? 16'd1 : 16'hFFFF;
      WAVE_TRI:    wave_next = ph_s3[16] ? ~tri_field : tri_field;
      WAVE_SAW:    wave_next = ph_s3[16:1];
      default:     wave_next = 16'h8000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ftw_act    <= '0;
      ph_s1      <= '0;
      wsel_s1    <= WAVE_SINE;
      ce_s1      <= 1'b0;
      addr_s2    <= '0;
      q1_s2      <= 1'b0;
      ph_s2      <= '0;
      wsel_s2    <= WAVE_SINE;
      ce_s2      <= 1'b0;
      rom_q      <= '0;
      q1_s3      <= 1'b0;
      ph_s3      <= '0;
      wsel_s3    <= WAVE_SINE;
      ce_s3      <= 1'b0;
      ce_s4      <= 1'b0;
      dout       <= 16'h8000;
      dout_valid <= 1'b0;
    end else begin
      if (sync)
        acc <= '0;
      else if (ce)
        acc <= acc + ftw_act;
      if (ftw_load)
        ftw_act <= ftw_in;

      ph_s1   <= acc[PHASE_W-1 -: PH_KEEP] + {poff, {(PH_KEEP-16){1'b0}}};
      wsel_s1 <= wave_t'(wsel);
      ce_s1   <= ce;

      addr_s2 <= ph_s1[PH_KEEP-2] ? ~idx : idx;
      q1_s2   <= ph_s1[PH_KEEP-1];
      ph_s2   <= ph_s1[PH_KEEP-1 -: 17];
      wsel_s2 <= wsel_s1;
      ce_s2   <= ce_s1;

      rom_q   <= rom[addr_s2];
      q1_s3   <= q1_s2;
      ph_s3   <= ph_s2;
      wsel_s3 <= wsel_s2;
      ce_s3   <= ce_s2;
      ce_s4   <= ce_s3;

      dout       <= wave_next;
      dout_valid <= ce_s4;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: a phase-level model queues each expected sample
// when its inputs are driven and compares it when the pipeline delivers it.
module tb_dds_wave_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] ftw_in;
  logic        ftw_load;
  logic [15:0] poff;
  logic [1:0]  wsel;
  logic        sync;
  logic [15:0] dout;
  logic        dout_valid;

  dds_wave_gen #(.PHASE_W(32), .LUT_AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .ftw_in     (ftw_in),
    .ftw_load   (ftw_load),
    .poff       (poff),
    .wsel       (wsel),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] dout;
    logic        valid;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_ftw = '0;
  logic        m_ce_prev = 1'b0;
  logic        rst_prev = 1'b0;
  string       phase = "reset";

  function automatic logic [15:0] wave(input logic [31:0] ph, input logic [1:0] ws);
    logic [9:0]  a;
    logic [15:0] f;
    int          r;
    case (ws)
      2'd0: begin
        a = ph[30] ? ~ph[29:20] : ph[29:20];
        r = $rtoi(32767.0 * $sin(PI / 2.0 * (real'(a) + 0.5) / 1024.0) + 0.5);
        return ph[31] ? 16'(32768 - r) : 16'(32768 + r);
      end
      2'd1: return ph[31] ? 16'd1 : 16'hFFFF;
      2'd2: begin
        f = ph[30:15];
        return ph[31] ? ~f : f;
      end
      default: return ph[31:16];
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s (edge %0d): observed %h expected %h", tag, cyc, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    if (rst) begin
      m_acc     = '0;
      m_ftw     = '0;
      m_ce_prev = 1'b0;
      sb.delete();
    end else begin
      e.due   = cyc + 3;
      e.dout  = wave(m_acc + {poff, 16'h0000}, wsel);
      e.valid = m_ce_prev;
      e.tag   = phase;
      sb.push_back(e);
      if (sync)
        m_acc = '0;
      else if (ce)
        m_acc = m_acc + m_ftw;
      if (ftw_load)
        m_ftw = ftw_in;
      m_ce_prev = ce;
    end
    @(posedge clk);
    #1;
    if (rst || rst_prev) begin
      check("reset_dout", dout, 16'h8000);
      check("reset_valid", {15'd0, dout_valid}, 16'd0);
    end
    rst_prev = rst;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check({e.tag, "_dout"}, dout, e.dout);
      check({e.tag, "_valid"}, {15'd0, dout_valid}, {15'd0, e.valid});
    end
    cyc++;
  endtask

  task automatic load_ftw(input logic [31:0] w);
    ftw_in   = w;
    ftw_load = 1'b1;
    step();
    ftw_load = 1'b0;
  endtask

  // Restart phase, then compare n samples against a repeating 4-value pattern.
  task automatic run_const(input string tag, input int n,
                           input logic [15:0] v0, input logic [15:0] v1,
                           input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] pat [4];
    pat[0] = v0; pat[1] = v1; pat[2] = v2; pat[3] = v3;
    ce   = 1'b1;
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (3) step();
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, dout, pat[i % 4]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    ce       = 1'b1;
    ftw_in   = 32'h4000_0000;
    ftw_load = 1'b1;
    poff     = 16'h0000;
    wsel     = 2'd0;
    sync     = 1'b0;

    phase = "reset";
    repeat (2) step();
    rst      = 1'b0;
    ftw_load = 1'b0;
    step();
    phase = "dc";
    repeat (4) step();

    phase = "sine";
    load_ftw(32'h4000_0000);
    run_const("sine_quad", 8, 16'd32793, 16'd65535, 16'd32743, 16'd1);

    phase = "saw";
    wsel = 2'd3;
    load_ftw(32'h1000_0000);
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (20) step();

    phase = "tri";
    wsel = 2'd2;
    repeat (20) step();

    phase = "square";
    wsel = 2'd1;
    poff = 16'h4000;
    load_ftw(32'h4000_0000);
    run_const("square_p4000", 8, 16'hFFFF, 16'd1, 16'd1, 16'hFFFF);
    poff = 16'hC000;
    repeat (6) step();
    run_const("square_pC000", 8, 16'd1, 16'hFFFF, 16'hFFFF, 16'd1);

    phase = "tune";
    wsel = 2'd3;
    poff = 16'h0000;
    load_ftw(32'h0100_0000);
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (6) step();
    ftw_in   = 32'h0200_0000;
    ftw_load = 1'b1;
    ce       = 1'b1;
    step();
    ftw_load = 1'b0;
    repeat (10) step();

    phase = "ce_gate";
    wsel = 2'd0;
    load_ftw(32'h4000_0000);
    repeat (3) step();
    ce = 1'b0;
    repeat (10) step();
    ce = 1'b1;
    repeat (6) step();
    run_const("sync_sine", 4, 16'd32793, 16'd65535, 16'd32743, 16'd1);

    phase = "midrst";
    wsel = 2'd2;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    phase = "post_rst";
    repeat (8) step();

    ce = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
